raster_scanner: RTL and testbench

RASTER_SCANNER -- requirements
Module: raster_scanner

---
 rtl/raster_scanner_if.sv | 32 +++
 rtl/raster_scanner.sv | 149 ++++++++++++++
 tb/tb_raster_scanner.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_scanner_if.sv
// Bounding-box in / pixel-coordinate out bundle for the raster scanner.
interface raster_scanner_if;
    localparam int unsigned COORD_W = 16;

    // Upstream: bounding box handshake
    logic               nd;
    logic               us_rfd;
    logic [COORD_W-1:0] min_x;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] max_y;

    // Downstream: pixel stream handshake
    logic               ds_rfd;
    logic               rdy;
    logic [COORD_W-1:0] p_x;
    logic [COORD_W-1:0] p_y;
    logic               last;
    logic               done;

    // Box producer / pixel consumer side
    modport master (
        output nd, min_x, min_y, max_x, max_y, ds_rfd,
        input  us_rfd, rdy, p_x, p_y, last, done
    );

    // Scanner side
    modport slave (
        input  nd, min_x, min_y, max_x, max_y, ds_rfd,
        output us_rfd, rdy, p_x, p_y, last, done
    );
endinterface

// File: rtl/raster_scanner.sv
// Raster scanner: walks every pixel of an inclusive bounding box in
// row-major order, one pixel per downstream transfer, then pulses done.
module raster_scanner (
    input  logic           clk,
    input  logic           rst,
    raster_scanner_if.slave bus
);
    localparam int unsigned COORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched box bounds (min_y only seeds the row counter, so it is not kept)
    logic [COORD_W-1:0] min_x_q, min_x_d;
    logic [COORD_W-1:0] max_x_q, max_x_d;
    logic [COORD_W-1:0] max_y_q, max_y_d;

    // Registered outputs
    logic [COORD_W-1:0] p_x_q, p_x_d;
    logic [COORD_W-1:0] p_y_q, p_y_d;
    logic               rdy_q, rdy_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               us_rfd_q, us_rfd_d;

    // Combinational helpers
    logic               accept_c;
    logic               xfer_c;
    logic               degen_c;
    logic               row_end_c;
    logic               box_end_c;
    logic               first_last_c;
    logic [COORD_W-1:0] p_x_inc_c;
    logic [COORD_W-1:0] p_y_inc_c;

    // Handshake qualifiers and pre-increment end detection
    assign accept_c     = bus.nd & us_rfd_q;
    assign xfer_c       = rdy_q & bus.ds_rfd;
    assign degen_c      = (bus.max_x < bus.min_x) || (bus.max_y < bus.min_y);
    assign first_last_c = (bus.min_x == bus.max_x) && (bus.min_y == bus.max_y);
    assign row_end_c    = (p_x_q == max_x_q);
    assign box_end_c    = row_end_c && (p_y_q == max_y_q);
    assign p_x_inc_c    = p_x_q + COORD_W'(1);
    assign p_y_inc_c    = p_y_q + COORD_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        min_x_d  = min_x_q;
        max_x_d  = max_x_q;
        max_y_d  = max_y_q;
        p_x_d    = p_x_q;
        p_y_d    = p_y_q;
        rdy_d    = rdy_q;
        last_d   = last_q;
        done_d   = 1'b0;
        us_rfd_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    min_x_d = bus.min_x;
                    max_x_d = bus.max_x;
                    max_y_d = bus.max_y;
                    if (degen_c) begin
                        state_d = FIN;
                    end else begin
                        state_d = SCAN;
                        p_x_d   = bus.min_x;
                        p_y_d   = bus.min_y;
                        rdy_d   = 1'b1;
                        last_d  = first_last_c;
                    end
                end
            end

            SCAN: begin
                // Counters only move on a transfer; a stall holds everything
                if (xfer_c) begin
                    if (box_end_c) begin
                        state_d = FIN;
                        rdy_d   = 1'b0;
                        last_d  = 1'b0;
                    end else if (row_end_c) begin
                        p_x_d  = min_x_q;
                        p_y_d  = p_y_inc_c;
                        last_d = (min_x_q == max_x_q) && (p_y_inc_c == max_y_q);
                    end else begin
                        p_x_d  = p_x_inc_c;
                        last_d = (p_x_inc_c == max_x_q) && (p_y_q == max_y_q);
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                rdy_d   = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        // done is the registered image of FIN, so it rises as IDLE is re-entered
        done_d   = (state_q == FIN);
        us_rfd_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            min_x_q  <= '0;
            max_x_q  <= '0;
            max_y_q  <= '0;
            p_x_q    <= '0;
            p_y_q    <= '0;
            rdy_q    <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            us_rfd_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            min_x_q  <= min_x_d;
            max_x_q  <= max_x_d;
            max_y_q  <= max_y_d;
            p_x_q    <= p_x_d;
            p_y_q    <= p_y_d;
            rdy_q    <= rdy_d;
            last_q   <= last_d;
            done_q   <= done_d;
            us_rfd_q <= us_rfd_d;
        end
    end

    assign bus.us_rfd = us_rfd_q;
    assign bus.rdy    = rdy_q;
    assign bus.p_x    = p_x_q;
    assign bus.p_y    = p_y_q;
    assign bus.last   = last_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_raster_scanner.sv
// Scoreboard bench for raster_scanner: stimulus queues expected pixels,
// done pulses and cycle probes; one monitor process does every comparison.
module tb_raster_scanner;
    localparam int K_STATE   = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_EMPTY   = 2;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
        int          cyc;
    } pix_t;

    typedef struct {
        int          kind;
        int          cyc;
        logic        rdy;
        logic        us_rfd;
        logic        done;
        bit          chk_p;
        logic [15:0] p_x;
        logic [15:0] p_y;
        logic        last;
    } probe_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    bit   stall_en = 0;

    int n_cmp = 0;
    int n_bad = 0;

    pix_t   exp_q[$];
    int     done_q[$];
    probe_t probe_q[$];
    string  probe_name_q[$];

    pix_t   mon_e;
    probe_t mon_p;
    string  mon_n;
    int     mon_d;

    raster_scanner_if bus ();

    raster_scanner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: always 1, or a 1,0,0 repeating pattern when stalling
    initial begin
        int ph;
        ph = 0;
        bus.ds_rfd = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en) begin
                bus.ds_rfd = (ph % 3 == 0);
                ph++;
            end else begin
                bus.ds_rfd = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_probe(input string name, input int at, input logic r, input logic u,
                              input logic d, input bit chk_p, input logic [15:0] px,
                              input logic [15:0] py, input logic l);
        probe_t p;
        p.kind = K_STATE; p.cyc = at; p.rdy = r; p.us_rfd = u; p.done = d;
        p.chk_p = chk_p; p.p_x = px; p.p_y = py; p.last = l;
        probe_q.push_back(p);
        probe_name_q.push_back(name);
    endtask

    task automatic push_flag(input string name, input int kind);
        probe_t p;
        p.kind = kind; p.cyc = cyc; p.rdy = 1'b0; p.us_rfd = 1'b0; p.done = 1'b0;
        p.chk_p = 1'b0; p.p_x = '0; p.p_y = '0; p.last = 1'b0;
        probe_q.push_back(p);
        probe_name_q.push_back(name);
    endtask

    // Queue the expected pixels of a box (optionally only the first 'limit'),
    // then present it for one cycle. Called just after a rising edge.
    task automatic run_box(input logic [15:0] ax, input logic [15:0] ay,
                           input logic [15:0] bx, input logic [15:0] by,
                           input bit timed, input int limit, input bit want_done);
        int   acc;
        int   n;
        pix_t e;
        acc = cyc;
        n   = 0;
        for (int y = int'(ay); y <= int'(by); y++) begin
            for (int x = int'(ax); x <= int'(bx); x++) begin
                if (limit < 0 || n < limit) begin
                    e.x    = 16'(x);
                    e.y    = 16'(y);
                    e.last = (x == int'(bx)) && (y == int'(by));
                    e.cyc  = timed ? acc + 1 + n : -1;
                    exp_q.push_back(e);
                end
                n++;
            end
        end
        if (want_done) done_q.push_back(timed ? acc + 2 + n : -1);
        push_probe("ready_at_accept", acc, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        bus.min_x = ax; bus.min_y = ay; bus.max_x = bx; bus.max_y = by;
        bus.nd = 1'b1;
        @(posedge clk);
        #1;
        bus.nd = 1'b0;
    endtask

    // Wait for all expectations to be consumed, then expect an idle cycle
    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) push_flag({name, "_timeout"}, K_TIMEOUT);
        push_probe({name, "_idle"}, cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: the only process that compares or counts
    always @(negedge clk) begin
        while (probe_q.size() != 0 && probe_q[0].cyc <= cyc) begin
            mon_p = probe_q.pop_front();
            mon_n = probe_name_q.pop_front();
            n_cmp++;
            if (mon_p.kind == K_TIMEOUT) begin
                n_bad++;
                $display("FAIL %s: got queues still pending at cyc %0d, want drained", mon_n, cyc);
            end else if (mon_p.kind == K_EMPTY) begin
                if (exp_q.size() != 0 || done_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL %s: got %0d pixels / %0d dones outstanding, want 0 / 0",
                             mon_n, exp_q.size(), done_q.size());
                end
            end else if (mon_p.cyc != cyc || bus.rdy !== mon_p.rdy || bus.us_rfd !== mon_p.us_rfd ||
                         bus.done !== mon_p.done ||
                         (mon_p.chk_p && (bus.p_x !== mon_p.p_x || bus.p_y !== mon_p.p_y ||
                                          bus.last !== mon_p.last))) begin
                n_bad++;
                $display("FAIL %s: got cyc=%0d rdy=%b us_rfd=%b done=%b last=%b p=(%h,%h) want cyc=%0d rdy=%b us_rfd=%b done=%b last=%b p=(%h,%h)",
                         mon_n, cyc, bus.rdy, bus.us_rfd, bus.done, bus.last, bus.p_x, bus.p_y,
                         mon_p.cyc, mon_p.rdy, mon_p.us_rfd, mon_p.done, mon_p.last, mon_p.p_x, mon_p.p_y);
            end
        end

        if (!rst && bus.rdy === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pixel: got (%h,%h) last=%b at cyc %0d, want no pixel",
                         bus.p_x, bus.p_y, bus.last, cyc);
            end else begin
                mon_e = exp_q[0];
                if (bus.p_x !== mon_e.x || bus.p_y !== mon_e.y || bus.last !== mon_e.last ||
                    (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
                    n_bad++;
                    $display("FAIL pixel: got (%h,%h) last=%b cyc=%0d, want (%h,%h) last=%b cyc=%0d",
                             bus.p_x, bus.p_y, bus.last, cyc, mon_e.x, mon_e.y, mon_e.last, mon_e.cyc);
                end
                if (bus.ds_rfd === 1'b1) void'(exp_q.pop_front());
            end
        end

        if (!rst && bus.done === 1'b1) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at cyc %0d, want done=0", cyc);
            end else begin
                mon_d = done_q.pop_front();
                if (mon_d >= 0 && mon_d != cyc) begin
                    n_bad++;
                    $display("FAIL done_timing: got done at cyc %0d, want cyc %0d", cyc, mon_d);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int acc;
        rst = 1'b1;
        bus.nd = 1'b1;
        bus.min_x = 16'd1; bus.min_y = 16'd1; bus.max_x = 16'd3; bus.max_y = 16'd3;
        repeat (2) @(posedge clk);
        #1;
        push_probe("reset_state", cyc, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
        bus.nd = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_probe("post_reset_idle", cyc, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
        @(posedge clk);
        #1;

        run_box(16'd2, 16'd3, 16'd4, 16'd4, 1'b1, -1, 1'b1);
        drain("box_2x3");

        stall_en = 1'b1;
        run_box(16'd2, 16'd3, 16'd4, 16'd4, 1'b0, -1, 1'b1);
        drain("box_stall");
        stall_en = 1'b0;
        @(posedge clk);
        #1;

        run_box(16'd7, 16'd7, 16'd7, 16'd7, 1'b1, -1, 1'b1);
        drain("single_pixel");

        run_box(16'd5, 16'd0, 16'd4, 16'd3, 1'b1, -1, 1'b1);
        drain("degenerate");

        run_box(16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, -1, 1'b1);
        drain("max_corner");

        // Reset mid-scan after three transfers of an 8x8 box
        acc = cyc;
        run_box(16'd10, 16'd20, 16'd17, 16'd27, 1'b1, 3, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_probe("abort_reset", acc + 5, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        run_box(16'd0, 16'd0, 16'd2, 16'd1, 1'b1, -1, 1'b1);
        drain("after_abort");

        push_flag("queues_empty", K_EMPTY);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
